// File: rtl/buzzer_pkg.sv
// Shared constants, step record and state codes for the buzzer pattern sequencer.
package buzzer_pkg;

   localparam int CLK_HZ    = 50_000_000;
   localparam int PW        = 20;
   localparam int MAX_STEPS = 8;
   localparam int SW        = $clog2(MAX_STEPS);

   localparam logic [1:0] ID_CLICK = 2'd0;
   localparam logic [1:0] ID_DONE  = 2'd1;
   localparam logic [1:0] ID_ERROR = 2'd2;

   localparam logic [PW-1:0] P_SILENT = '0;
   localparam logic [PW-1:0] P_4K     = PW'(CLK_HZ / 4_000 - 1);
   localparam logic [PW-1:0] P_2K     = PW'(CLK_HZ / 2_000 - 1);
   localparam logic [PW-1:0] P_1K     = PW'(CLK_HZ / 1_000 - 1);
   localparam logic [PW-1:0] P_500    = PW'(CLK_HZ / 500 - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;

   typedef struct packed {
      logic [PW-1:0] period;
      logic [9:0]    len;
      logic          last;
   } step_t;

   function automatic step_t mk_step(logic [PW-1:0] period, logic [9:0] len, logic last);
      step_t s;
      s.period = period;
      s.len    = len;
      s.last   = last;
      return s;
   endfunction

endpackage

// File: rtl/buzzer_if.sv
// Request/tone bundle between the bottling control FSM (master) and the sequencer (slave).
interface buzzer_if #(
   parameter int N = 20
) ();
   logic [2:0]   req;
   logic [N-1:0] full_cycle;
   logic [N-1:0] duty_cycle;
   logic         busy;
   logic [1:0]   active_id;
   logic         done;

   modport master (
      output req,
      input  full_cycle, duty_cycle, busy, active_id, done
   );

   modport slave (
      input  req,
      output full_cycle, duty_cycle, busy, active_id, done
   );
endinterface

// File: rtl/buzzer_pattern_rom.sv
// Combinational beep-pattern table addressed by {pattern id, step}.
module buzzer_pattern_rom
   import buzzer_pkg::*;
(
   input  logic [1:0]    i_id,
   input  logic [SW-1:0] i_step,
   output step_t         o_step
);

   always_comb begin
      o_step = mk_step(P_SILENT, 10'd1, 1'b1);
      case ({i_id, i_step})
         {ID_CLICK, 3'd0}: o_step = mk_step(P_4K,     10'd20,  1'b1);
         {ID_DONE,  3'd0}: o_step = mk_step(P_1K,     10'd100, 1'b0);
         {ID_DONE,  3'd1}: o_step = mk_step(P_SILENT, 10'd50,  1'b0);
         {ID_DONE,  3'd2}: o_step = mk_step(P_2K,     10'd100, 1'b1);
         {ID_ERROR, 3'd0}: o_step = mk_step(P_500,    10'd200, 1'b0);
         {ID_ERROR, 3'd1}: o_step = mk_step(P_SILENT, 10'd100, 1'b0);
         {ID_ERROR, 3'd2}: o_step = mk_step(P_500,    10'd200, 1'b0);
         {ID_ERROR, 3'd3}: o_step = mk_step(P_SILENT, 10'd100, 1'b0);
         {ID_ERROR, 3'd4}: o_step = mk_step(P_500,    10'd200, 1'b1);
         default:          o_step = mk_step(P_SILENT, 10'd1,   1'b1);
      endcase
   end

endmodule

// File: rtl/buzzer_sequencer.sv
// Latches click/fill-done/error requests and plays their beep patterns by fixed priority.
// state | meaning
// IDLE  | silent; picks the highest pending request
// LOAD  | registers the current ROM step into the tone outputs
// PLAY  | holds the tone for len ticks, then next step or done
module buzzer_sequencer
   import buzzer_pkg::*;
#(
   parameter int N           = 20,
   parameter int TICK_CYCLES = 50000
) (
   input logic     clk,
   input logic     reset_n,
   buzzer_if.slave bus
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [1:0]    r_state;
   logic [2:0]    r_pend;
   logic [1:0]    r_id;
   logic [SW-1:0] r_step;
   logic [TW-1:0] r_tick;
   logic [9:0]    r_unit;
   logic [N-1:0]  r_full;
   logic [N-1:0]  r_duty;
   logic          r_busy;
   logic [1:0]    r_active;
   logic          r_done;

   step_t         w_step;
   logic [9:0]    w_len;
   logic [PW:0]   w_duty;
   logic [1:0]    w_sel;
   logic [2:0]    w_clr;
   logic          w_preempt;
   logic          w_tick_end;
   logic          w_unit_end;

   buzzer_pattern_rom u_rom (
      .i_id   (r_id),
      .i_step (r_step),
      .o_step (w_step)
   );

   assign w_len      = (w_step.len == 10'd0) ? 10'd1 : w_step.len;
   assign w_duty     = ({1'b0, w_step.period} + {{PW{1'b0}}, 1'b1}) >> 1;
   assign w_tick_end = (r_tick == TW'(TICK_CYCLES - 1));
   assign w_unit_end = ((r_unit + 10'd1) == w_len);
   assign w_sel      = r_pend[2] ? ID_ERROR : (r_pend[1] ? ID_DONE : ID_CLICK);

   always_comb begin
      w_preempt = 1'b0;
      case (r_id)
         ID_CLICK: w_preempt = |r_pend[2:1];
         ID_DONE:  w_preempt = r_pend[2];
         default:  w_preempt = 1'b0;
      endcase
   end

   always_comb begin
      w_clr = 3'b000;
      if (r_state == ST_IDLE && |r_pend) w_clr[w_sel] = 1'b1;
   end

   // A request landing on the bit being cleared survives, so that pattern replays later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pend <= 3'b000;
      else          r_pend <= (r_pend & ~w_clr) | bus.req;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_id     <= ID_CLICK;
         r_step   <= '0;
         r_tick   <= '0;
         r_unit   <= '0;
         r_full   <= '0;
         r_duty   <= '0;
         r_busy   <= 1'b0;
         r_active <= 2'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|r_pend) begin
                  r_id     <= w_sel;
                  r_active <= w_sel;
                  r_step   <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_preempt) begin
                  r_full   <= '0;
                  r_duty   <= '0;
                  r_busy   <= 1'b0;
                  r_active <= 2'd0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_full  <= N'(w_step.period);
                  r_duty  <= N'(w_duty);
                  r_tick  <= '0;
                  r_unit  <= '0;
                  r_state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (w_preempt) begin
                  r_full   <= '0;
                  r_duty   <= '0;
                  r_busy   <= 1'b0;
                  r_active <= 2'd0;
                  r_state  <= ST_IDLE;
               end else if (w_tick_end) begin
                  r_tick <= '0;
                  if (w_unit_end) begin
                     if (w_step.last) begin
                        r_full   <= '0;
                        r_duty   <= '0;
                        r_busy   <= 1'b0;
                        r_active <= 2'd0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                     end else begin
                        r_step  <= r_step + SW'(1);
                        r_state <= ST_LOAD;
                     end
                  end else begin
                     r_unit <= r_unit + 10'd1;
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.full_cycle = r_full;
   assign bus.duty_cycle = r_duty;
   assign bus.busy       = r_busy;
   assign bus.active_id  = r_active;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench: a timeline model predicts every output change, a monitor pops and compares.
module tb_buzzer_sequencer;

   localparam int T = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   buzzer_if #(.N(20)) bif ();

   buzzer_sequencer #(.N(20), .TICK_CYCLES(T)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif.slave)
   );

   typedef struct {
      logic [43:0] v;
      int          edge_n;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  edge_n = 0;

   int pat_n[3]      = '{1, 3, 5};
   int pat_per[3][5] = '{'{12499, 0, 0, 0, 0},
                         '{49999, 0, 24999, 0, 0},
                         '{99999, 0, 99999, 0, 99999}};
   int pat_len[3][5] = '{'{20, 0, 0, 0, 0},
                         '{100, 50, 100, 0, 0},
                         '{200, 100, 200, 100, 200}};

   bit          m_pend[3];
   bit          m_play = 1'b0;
   bit          m_done = 1'b0;
   int          m_id = 0;
   int          m_start = 0;
   logic [43:0] m_prev = '0;
   logic [43:0] dut_prev = '0;

   function automatic int pat_total(int id);
      int t = 0;
      for (int j = 0; j < pat_n[id]; j++) t += pat_len[id][j] * T + 1;
      return t;
   endfunction

   // Tone of each step starts one edge after its LOAD edge; offset 0 is the selection edge.
   function automatic logic [39:0] tone_at(int id, int o);
      logic [39:0] r = '0;
      int start = 1;
      for (int j = 0; j < pat_n[id]; j++) begin
         if (o >= start) r = {20'(pat_per[id][j]), 20'((pat_per[id][j] + 1) / 2)};
         start += pat_len[id][j] * T + 1;
      end
      return r;
   endfunction

   function automatic bit any_pend();
      return m_pend[0] | m_pend[1] | m_pend[2];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      logic [43:0] e;
      bit          higher;
      ev_t         ev;
      if (!reset_n) begin
         for (int b = 0; b < 3; b++) m_pend[b] = 1'b0;
         m_play = 1'b0;
         m_done = 1'b0;
      end else begin
         edge_n++;
         m_done = 1'b0;
         if (m_play) begin
            higher = 1'b0;
            for (int b = m_id + 1; b < 3; b++) if (m_pend[b]) higher = 1'b1;
            if (higher) m_play = 1'b0;
            else if (edge_n == m_start + pat_total(m_id)) begin
               m_play = 1'b0;
               m_done = 1'b1;
            end
         end else if (any_pend()) begin
            m_id = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
            m_pend[m_id] = 1'b0;
            m_play = 1'b1;
            m_start = edge_n;
         end
         for (int b = 0; b < 3; b++) if (bif.req[b]) m_pend[b] = 1'b1;
      end
      e = m_play ? {1'b0, 1'b1, 2'(m_id), tone_at(m_id, edge_n - m_start)} : {m_done, 43'b0};
      if (e !== m_prev) begin
         ev.v = e;
         ev.edge_n = edge_n;
         exp_q.push_back(ev);
         m_prev = e;
      end
   end

   always @(negedge clk) begin
      logic [43:0] cur;
      ev_t         ev;
      cur = {bif.done, bif.busy, bif.active_id, bif.full_cycle, bif.duty_cycle};
      if (cur !== dut_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %h at edge %0d, no change expected", cur, edge_n);
         end else begin
            ev = exp_q.pop_front();
            if (ev.v !== cur || ev.edge_n != edge_n) begin
               errors++;
               $display("FAIL output_event: got %h at edge %0d, want %h at edge %0d",
                        cur, edge_n, ev.v, ev.edge_n);
            end
         end
         dut_prev = cur;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [2:0] r);
      bif.req = r;
      @(negedge clk);
      bif.req = 3'b000;
   endtask

   task automatic check_silent(input string name);
      checks++;
      if (bif.full_cycle !== 20'd0 || bif.duty_cycle !== 20'd0 || bif.busy !== 1'b0 ||
          bif.active_id !== 2'd0 || bif.done !== 1'b0) begin
         errors++;
         $display("FAIL %s: got full=%0d duty=%0d busy=%b id=%0d done=%b, want all 0",
                  name, bif.full_cycle, bif.duty_cycle, bif.busy, bif.active_id, bif.done);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while ((m_play || any_pend()) && k < budget) begin
         @(negedge clk);
         k++;
      end
      idle(4);
      checks++;
      if (m_play || any_pend()) begin
         errors++;
         $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, budget);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d expected events not seen, want 0", name, exp_q.size());
      end
   endtask

   initial begin
      bif.req = 3'b000;
      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(100);
      check_silent("reset_state");

      pulse(3'b001);
      drain("click", 500);

      pulse(3'b010);
      drain("done_pat", 2000);

      pulse(3'b010);
      idle(500);
      pulse(3'b100);
      drain("preempt", 6000);

      pulse(3'b100);
      idle(1000);
      pulse(3'b001);
      drain("queue", 6000);

      pulse(3'b111);
      drain("all_three", 10000);

      bif.req = 3'b010;
      idle(2);
      bif.req = 3'b000;
      drain("set_wins", 4000);

      pulse(3'b010);
      idle(300);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_silent("async_reset");
      idle(2);
      reset_n = 1'b1;
      idle(200);
      check_silent("after_reset");
      drain("reset_quiet", 10);

      for (int i = 0; i < 6000; i++) begin
         bif.req = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         @(negedge clk);
      end
      bif.req = 3'b000;
      drain("random", 15000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
